// File: rtl/resq_dispatch_ctrl_if.sv
// resq_dispatch_ctrl_if: groups the station request bus, the ResQ core strobes
// and status, the responder handshake and the dispatch outputs of the controller.
// The slave modport is the controller's view. The master modport is the view of
// the surrounding stations, core and responder team.
interface resq_dispatch_ctrl_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   Req_Valid;
  logic [8*N_REQ-1:0] Req_Zone;
  logic [2*N_REQ-1:0] Req_Priority;
  logic [2*N_REQ-1:0] Req_Resource;
  logic [N_REQ-1:0]   Req_Ready;

  logic       Core_Insert;
  logic       Core_Serve;
  logic [7:0] Core_Zone;
  logic [1:0] Core_Priority;
  logic [1:0] Core_Resource;
  logic       Core_Evac_Empty;
  logic       Core_Shelter_Valid;
  logic       Core_Food_Valid;
  logic       Core_Food_00;
  logic       Core_Shelter_01;
  logic       Core_Evacuation_10;
  logic [7:0] Core_Out_Zone;
  logic [1:0] Core_Out_Priority;

  logic       Team_Ready;
  logic       Team_Ack;
  logic       Dispatch_Valid;
  logic [7:0] Dispatch_Zone;
  logic [1:0] Dispatch_Priority;
  logic [1:0] Dispatch_Resource;
  logic [7:0] Reject_Count;
  logic       Dispatch_Timeout;

  modport slave (
    input  Req_Valid, Req_Zone, Req_Priority, Req_Resource,
    output Req_Ready,
    output Core_Insert, Core_Serve, Core_Zone, Core_Priority, Core_Resource,
    input  Core_Evac_Empty, Core_Shelter_Valid, Core_Food_Valid,
    input  Core_Food_00, Core_Shelter_01, Core_Evacuation_10,
    input  Core_Out_Zone, Core_Out_Priority,
    input  Team_Ready, Team_Ack,
    output Dispatch_Valid, Dispatch_Zone, Dispatch_Priority, Dispatch_Resource,
    output Reject_Count, Dispatch_Timeout
  );

  modport master (
    output Req_Valid, Req_Zone, Req_Priority, Req_Resource,
    input  Req_Ready,
    input  Core_Insert, Core_Serve, Core_Zone, Core_Priority, Core_Resource,
    output Core_Evac_Empty, Core_Shelter_Valid, Core_Food_Valid,
    output Core_Food_00, Core_Shelter_01, Core_Evacuation_10,
    output Core_Out_Zone, Core_Out_Priority,
    output Team_Ready, Team_Ack,
    input  Dispatch_Valid, Dispatch_Zone, Dispatch_Priority, Dispatch_Resource,
    input  Reject_Count, Dispatch_Timeout
  );
endinterface

// File: rtl/resq_dispatch_ctrl.sv
// resq_dispatch_ctrl: sequencing controller in front of the ResQ three-queue core.
// It grants station requests round-robin into the core (one per INS cycle) and
// serves the core head into a dispatch register that is held until the team acks.
// Optional feature macro: DISPATCH_TIMEOUT_EN enables the dispatch-acknowledge
// watchdog (TIMEOUT cycles in DISP without Team_Ack returns the FSM to IDLE).
module resq_dispatch_ctrl #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input logic                  Clock,
  input logic                  Reset,
  resq_dispatch_ctrl_if.slave  bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, INS, SRV, DISP} state_t;
  typedef enum logic {OP_INS, OP_SRV} op_t;

  // Reject out-of-range parameters at elaboration time
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("resq_dispatch_ctrl: N_REQ must be 2..8 and TIMEOUT 1..255");
  end

  state_t           state_q, state_d;
  op_t              last_op_q, last_op_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             core_insert_q, core_insert_d;
  logic             core_serve_q, core_serve_d;
  logic [7:0]       core_zone_q, core_zone_d;
  logic [1:0]       core_prio_q, core_prio_d;
  logic [1:0]       core_res_q, core_res_d;
  logic             disp_valid_q, disp_valid_d;
  logic [7:0]       disp_zone_q, disp_zone_d;
  logic [1:0]       disp_prio_q, disp_prio_d;
  logic [1:0]       disp_res_q, disp_res_d;
  logic [7:0]       reject_cnt_q, reject_cnt_d;
`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0]       wd_cnt_q, wd_cnt_d;
  logic             wd_expire;
`endif

  logic             grant_found;
  logic [PW-1:0]    grant_idx;
  logic             pending;
  logic [1:0]       head_res;

  assign pending = ~bus.Core_Evac_Empty | bus.Core_Shelter_Valid | bus.Core_Food_Valid;

  // Round-robin search for the first valid station at or after ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && bus.Req_Valid[(int'(ptr_q) + i) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // Encode the core's one-hot head-source indicators; 11 means no source asserted
  always_comb begin
    if (bus.Core_Food_00)            head_res = 2'b00;
    else if (bus.Core_Shelter_01)    head_res = 2'b01;
    else if (bus.Core_Evacuation_10) head_res = 2'b10;
    else                             head_res = 2'b11;
  end

`ifdef DISPATCH_TIMEOUT_EN
  assign wd_expire = (state_q == DISP) && !bus.Team_Ack && (wd_cnt_q == 8'(TIMEOUT - 1));
`endif

  // Next-state and registered-output computation for the IDLE/INS/SRV/DISP sequencer
  always_comb begin
    state_d       = state_q;
    last_op_d     = last_op_q;
    ptr_d         = ptr_q;
    req_ready_d   = '0;
    core_insert_d = 1'b0;
    core_serve_d  = 1'b0;
    core_zone_d   = 8'h00;
    core_prio_d   = 2'b00;
    core_res_d    = 2'b00;
    disp_valid_d  = 1'b0;
    disp_zone_d   = disp_zone_q;
    disp_prio_d   = disp_prio_q;
    disp_res_d    = disp_res_q;
    reject_cnt_d  = reject_cnt_q;
`ifdef DISPATCH_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pending && bus.Team_Ready && (!grant_found || last_op_q == OP_INS)) begin
          state_d      = SRV;
          last_op_d    = OP_SRV;
          core_serve_d = 1'b1;
        end else if (grant_found) begin
          state_d        = INS;
          last_op_d      = OP_INS;
          ptr_d          = PW'((int'(grant_idx) + 1) % N_REQ);
          req_ready_d    = N_REQ'(1) << grant_idx;
          core_zone_d    = bus.Req_Zone[8*int'(grant_idx) +: 8];
          core_prio_d    = bus.Req_Priority[2*int'(grant_idx) +: 2];
          core_res_d     = bus.Req_Resource[2*int'(grant_idx) +: 2];
          core_insert_d  = (bus.Req_Resource[2*int'(grant_idx) +: 2] != 2'b11);
        end
      end
      INS: begin
        state_d = IDLE;
        if (core_res_q == 2'b11 && reject_cnt_q != 8'hFF) begin
          reject_cnt_d = reject_cnt_q + 8'd1;
        end
      end
      SRV: begin
        state_d      = DISP;
        disp_valid_d = 1'b1;
        disp_zone_d  = bus.Core_Out_Zone;
        disp_prio_d  = bus.Core_Out_Priority;
        disp_res_d   = head_res;
`ifdef DISPATCH_TIMEOUT_EN
        wd_cnt_d     = 8'd0;
`endif
      end
      DISP: begin
        disp_valid_d = 1'b1;
        if (bus.Team_Ack) begin
          state_d      = IDLE;
          disp_valid_d = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        end else if (wd_expire) begin
          state_d      = IDLE;
          disp_valid_d = 1'b0;
        end else begin
          wd_cnt_d     = wd_cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      last_op_q     <= OP_SRV;
      ptr_q         <= '0;
      req_ready_q   <= '0;
      core_insert_q <= 1'b0;
      core_serve_q  <= 1'b0;
      core_zone_q   <= 8'h00;
      core_prio_q   <= 2'b00;
      core_res_q    <= 2'b00;
      disp_valid_q  <= 1'b0;
      disp_zone_q   <= 8'h00;
      disp_prio_q   <= 2'b00;
      disp_res_q    <= 2'b00;
      reject_cnt_q  <= 8'h00;
`ifdef DISPATCH_TIMEOUT_EN
      wd_cnt_q      <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      last_op_q     <= last_op_d;
      ptr_q         <= ptr_d;
      req_ready_q   <= req_ready_d;
      core_insert_q <= core_insert_d;
      core_serve_q  <= core_serve_d;
      core_zone_q   <= core_zone_d;
      core_prio_q   <= core_prio_d;
      core_res_q    <= core_res_d;
      disp_valid_q  <= disp_valid_d;
      disp_zone_q   <= disp_zone_d;
      disp_prio_q   <= disp_prio_d;
      disp_res_q    <= disp_res_d;
      reject_cnt_q  <= reject_cnt_d;
`ifdef DISPATCH_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign bus.Req_Ready         = req_ready_q;
  assign bus.Core_Insert       = core_insert_q;
  assign bus.Core_Serve        = core_serve_q;
  assign bus.Core_Zone         = core_zone_q;
  assign bus.Core_Priority     = core_prio_q;
  assign bus.Core_Resource     = core_res_q;
  assign bus.Dispatch_Valid    = disp_valid_q;
  assign bus.Dispatch_Zone     = disp_zone_q;
  assign bus.Dispatch_Priority = disp_prio_q;
  assign bus.Dispatch_Resource = disp_res_q;
  assign bus.Reject_Count      = reject_cnt_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign bus.Dispatch_Timeout  = wd_expire;
`else
  assign bus.Dispatch_Timeout  = 1'b0;
`endif

endmodule
